// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM state encoding,
// ASCII constants and hex/ASCII conversion helpers.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_CMD  = 3'd1,
        S_DATA = 3'd2,
        S_EOL  = 3'd3,
        S_EXEC = 3'd4,
        S_RD   = 3'd5,
        S_RESP = 3'd6,
        S_DISC = 3'd7
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters of either case have bit 6 set and low nibble 1..6.
    function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
        if (c[6]) begin
            return c[3:0] + 4'd9;
        end else begin
            return c[3:0];
        end
    endfunction

    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return {4'h3, n};
        end else begin
            return 8'h57 + {4'h0, n};
        end
    endfunction

endpackage

// File: rtl/uart_cmd_resp_tx.sv
// Response byte sequencer: emits a read word as lowercase hex plus LF,
// or the write acknowledge "OK\n", over a valid/ready byte interface.
module uart_cmd_resp_tx
    import uart_cmd_pkg::*;
#(
    parameter int DATA_NIB = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_rd,
    input  logic                  start_ack,
    input  logic [4*DATA_NIB-1:0] rd_word,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  done
);

    localparam int DW    = 4 * DATA_NIB;
    localparam int IDX_W = $clog2(DATA_NIB + 2);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] HEX_LAST = IDX_W'(DATA_NIB - 1);
    localparam logic [IDX_W-1:0] RD_LAST  = IDX_W'(DATA_NIB);
    localparam logic [IDX_W-1:0] ACK_LAST = IDX_W'(2);

    logic [7:0]       tx_data_r;
    logic             tx_valid_r;
    logic [IDX_W-1:0] idx_r;
    logic [DW-1:0]    word_r;
    logic             ack_mode_r;
    logic [7:0]       next_byte_s;
    logic             hs_s;
    logic             last_s;

    assign hs_s   = tx_valid_r & tx_ready;
    assign last_s = ack_mode_r ? (idx_r == ACK_LAST) : (idx_r == RD_LAST);
    assign done   = hs_s & last_s;

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

    // Byte that follows the one currently on tx_data.
    always_comb begin
        next_byte_s = ASCII_LF;
        if (ack_mode_r) begin
            if (idx_r == IDX_ZERO) begin
                next_byte_s = ASCII_K;
            end else begin
                next_byte_s = ASCII_LF;
            end
        end else begin
            if (idx_r < HEX_LAST) begin
                next_byte_s = nib_to_hex(word_r[DW-1 -: 4]);
            end else begin
                next_byte_s = ASCII_LF;
            end
        end
    end

    // Sequencer state; word_r always holds the next nibble at its top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            idx_r      <= IDX_ZERO;
            word_r     <= {DW{1'b0}};
            ack_mode_r <= 1'b0;
        end else if (start_rd) begin
            tx_data_r  <= nib_to_hex(rd_word[DW-1 -: 4]);
            tx_valid_r <= 1'b1;
            idx_r      <= IDX_ZERO;
            word_r     <= rd_word << 3'd4;
            ack_mode_r <= 1'b0;
        end else if (start_ack) begin
            tx_data_r  <= ASCII_O;
            tx_valid_r <= 1'b1;
            idx_r      <= IDX_ZERO;
            ack_mode_r <= 1'b1;
        end else if (hs_s) begin
            if (last_s) begin
                tx_valid_r <= 1'b0;
                tx_data_r  <= 8'h00;
            end else begin
                tx_data_r <= next_byte_s;
                idx_r     <= idx_r + IDX_ONE;
                word_r    <= word_r << 3'd4;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII register-access command parser ("AAAAWDDDD\n" / "AAAAR\n").
// Define UART_CMD_WR_ACK_EN to answer each write with "OK\n".
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_NIB = 4,
    parameter int         DATA_NIB = 4,
    parameter logic [7:0] WR_CHAR  = 8'h57,
    parameter logic [7:0] RD_CHAR  = 8'h52
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  reg_wr_en,
    output logic [4*ADDR_NIB-1:0] reg_wr_addr,
    output logic [4*DATA_NIB-1:0] reg_wr_data,
    output logic                  reg_rd_en,
    output logic [4*ADDR_NIB-1:0] reg_rd_addr,
    input  logic [4*DATA_NIB-1:0] reg_rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  cmd_err
);

    localparam int AW      = 4 * ADDR_NIB;
    localparam int DW      = 4 * DATA_NIB;
    localparam int MAX_NIB = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
    localparam int CNT_W   = $clog2(MAX_NIB + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NIB - 1);

`ifdef UART_CMD_WR_ACK_EN
    localparam logic ACK_EN = 1'b1;
`else
    localparam logic ACK_EN = 1'b0;
`endif

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [AW-1:0]    addr_sh_r, addr_sh_nxt_s;
    logic [DW-1:0]    data_sh_r, data_sh_nxt_s;
    logic             is_wr_r, is_wr_nxt_s;
    logic [AW-1:0]    wr_addr_r, wr_addr_nxt_s;
    logic [DW-1:0]    wr_data_r, wr_data_nxt_s;
    logic [AW-1:0]    rd_addr_r, rd_addr_nxt_s;
    logic             wr_en_r, wr_en_nxt_s;
    logic             rd_en_r, rd_en_nxt_s;
    logic             err_r, err_nxt_s;
    logic             start_rd_s, start_ack_s, resp_done_s;
    logic             acc_s, is_lf_s, is_hex_s;
    logic [3:0]       nib_s;

    // CR is transparent everywhere, so it never counts as an accepted byte.
    assign acc_s    = rx_valid && (rx_data != ASCII_CR);
    assign is_lf_s  = (rx_data == ASCII_LF);
    assign is_hex_s = is_hex(rx_data);
    assign nib_s    = hex_to_nib(rx_data);

    assign reg_wr_en   = wr_en_r;
    assign reg_wr_addr = wr_addr_r;
    assign reg_wr_data = wr_data_r;
    assign reg_rd_en   = rd_en_r;
    assign reg_rd_addr = rd_addr_r;
    assign cmd_err     = err_r;

    // Next-state and datapath decode for the frame parser.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        addr_sh_nxt_s = addr_sh_r;
        data_sh_nxt_s = data_sh_r;
        is_wr_nxt_s   = is_wr_r;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        rd_addr_nxt_s = rd_addr_r;
        wr_en_nxt_s   = 1'b0;
        rd_en_nxt_s   = 1'b0;
        err_nxt_s     = 1'b0;
        start_rd_s    = 1'b0;
        start_ack_s   = 1'b0;

        case (state_r)
            S_ADDR: begin
                if (acc_s) begin
                    if (is_lf_s) begin
                        err_nxt_s = (cnt_r != CNT_ZERO);
                        cnt_nxt_s = CNT_ZERO;
                    end else if (is_hex_s) begin
                        addr_sh_nxt_s = (addr_sh_r << 3'd4) | AW'(nib_s);
                        if (cnt_r == ADDR_LAST) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = S_CMD;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_DISC;
                    end
                end else begin
                    state_nxt_s = S_ADDR;
                end
            end
            S_CMD: begin
                if (acc_s) begin
                    if (rx_data == WR_CHAR) begin
                        is_wr_nxt_s = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_DATA;
                    end else if (rx_data == RD_CHAR) begin
                        is_wr_nxt_s = 1'b0;
                        state_nxt_s = S_EOL;
                    end else if (is_lf_s) begin
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_ADDR;
                    end else begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = S_DISC;
                    end
                end else begin
                    state_nxt_s = S_CMD;
                end
            end
            S_DATA: begin
                if (acc_s) begin
                    if (is_hex_s) begin
                        data_sh_nxt_s = (data_sh_r << 3'd4) | DW'(nib_s);
                        if (cnt_r == DATA_LAST) begin
                            cnt_nxt_s   = CNT_ZERO;
                            state_nxt_s = S_EOL;
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end
                    end else if (is_lf_s) begin
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_ADDR;
                    end else begin
                        err_nxt_s   = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = S_DISC;
                    end
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_EOL: begin
                if (acc_s) begin
                    if (is_lf_s) begin
                        if (is_wr_r) begin
                            wr_en_nxt_s   = 1'b1;
                            wr_addr_nxt_s = addr_sh_r;
                            wr_data_nxt_s = data_sh_r;
                        end else begin
                            rd_en_nxt_s   = 1'b1;
                            rd_addr_nxt_s = addr_sh_r;
                        end
                        state_nxt_s = S_EXEC;
                    end else begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = S_DISC;
                    end
                end else begin
                    state_nxt_s = S_EOL;
                end
            end
            S_EXEC: begin
                err_nxt_s = acc_s;
                if (is_wr_r) begin
                    if (ACK_EN) begin
                        start_ack_s = 1'b1;
                        state_nxt_s = S_RESP;
                    end else begin
                        state_nxt_s = S_ADDR;
                    end
                end else begin
                    state_nxt_s = S_RD;
                end
            end
            S_RD: begin
                // reg_rd_data is valid now, one cycle after reg_rd_en.
                err_nxt_s   = acc_s;
                start_rd_s  = 1'b1;
                state_nxt_s = S_RESP;
            end
            S_RESP: begin
                err_nxt_s = acc_s;
                if (resp_done_s) begin
                    state_nxt_s = S_ADDR;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            S_DISC: begin
                if (acc_s && is_lf_s) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = S_ADDR;
                end else begin
                    state_nxt_s = S_DISC;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = S_ADDR;
            end
        endcase
    end

    // Parser state, captured fields and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_ADDR;
            cnt_r     <= CNT_ZERO;
            addr_sh_r <= {AW{1'b0}};
            data_sh_r <= {DW{1'b0}};
            is_wr_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {DW{1'b0}};
            rd_addr_r <= {AW{1'b0}};
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            addr_sh_r <= addr_sh_nxt_s;
            data_sh_r <= data_sh_nxt_s;
            is_wr_r   <= is_wr_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            rd_en_r   <= rd_en_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    uart_cmd_resp_tx #(
        .DATA_NIB (DATA_NIB)
    ) u_resp_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_rd  (start_rd_s),
        .start_ack (start_ack_s),
        .rd_word   (reg_rd_data),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (resp_done_s)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser (default parameters).
module tb_uart_cmd_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reg_wr_en;
    logic [15:0] reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cmd_err;

`ifdef UART_CMD_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    uart_cmd_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .cmd_err     (cmd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_wr, n_rd, n_err, wr_cyc, rd_cyc, lf_cyc;
    logic [15:0] wr_a, wr_d, rd_a;
    logic [7:0]  txq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are sampled mid-cycle; inputs change 2ns after the rising edge.
    always @(negedge clk) begin
        if (reg_wr_en) begin n_wr++; wr_a = reg_wr_addr; wr_d = reg_wr_data; wr_cyc = cyc; end
        if (reg_rd_en) begin n_rd++; rd_a = reg_rd_addr; rd_cyc = cyc; end
        if (cmd_err) n_err++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (rx_valid && rx_data == 8'h0A) lf_cyc = cyc;
    end

    typedef struct {
        int          n_wr;
        int          n_rd;
        int          n_err;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rd_val;
    } vec_t;

    vec_t  vecs[16];
    string frames[16];
    string exp_tx[16];
    int    nv = 0;

    task automatic add_vec(input string f, input string t, input int nw, input int nr,
                           input int ne, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] rv);
        frames[nv] = f;
        exp_tx[nv] = t;
        vecs[nv]   = '{nw, nr, ne, a, d, rv};
        nv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input string f);
        for (int i = 0; i < f.len(); i++) send_byte(f[i]);
    endtask

    task automatic clear_mon();
        n_wr = 0; n_rd = 0; n_err = 0;
        wr_cyc = 0; rd_cyc = 0; lf_cyc = 0;
        txq.delete();
    endtask

    task automatic check_tx(input string name, input string t);
        check({name, "_txlen"}, txq.size(), t.len());
        for (int i = 0; i < t.len() && i < txq.size(); i++)
            check($sformatf("%s_tx%0d", name, i), {24'h0, txq[i]}, {24'h0, t[i]});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wr_en"},  {31'h0, reg_wr_en}, 32'h0);
        check({name, "_rd_en"},  {31'h0, reg_rd_en}, 32'h0);
        check({name, "_err"},    {31'h0, cmd_err},   32'h0);
        check({name, "_txv"},    {31'h0, tx_valid},  32'h0);
        check({name, "_txd"},    {24'h0, tx_data},   32'h0);
        check({name, "_wr_addr"}, {16'h0, reg_wr_addr}, 32'h0);
        check({name, "_wr_data"}, {16'h0, reg_wr_data}, 32'h0);
        check({name, "_rd_addr"}, {16'h0, reg_rd_addr}, 32'h0);
    endtask

    initial begin
        string t;
        string nm;
        logic [7:0] first;
        int bad;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tx_ready = 1'b1; reg_rd_data = 16'h0000;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;

        add_vec("0003W5555\n", "", 1, 0, 0, 16'h0003, 16'h5555, 16'h0000);
        add_vec("000aR\n", "aaaa\n", 0, 1, 0, 16'h000A, 16'h0000, 16'hAAAA);
        add_vec("00G1W1234\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("1234W00ff\n", "", 1, 0, 0, 16'h1234, 16'h00FF, 16'h0000);
        add_vec("\n\01500FfW0001\015\n", "", 1, 0, 0, 16'h00FF, 16'h0001, 16'h0000);
        add_vec("BEEFR\n", "1234\n", 0, 1, 0, 16'hBEEF, 16'h0000, 16'h1234);
        add_vec("0001X\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("00\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("0002W12\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("0003R5\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("0004W123g\n", "", 0, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("c0deR\n", "9f0b\n", 0, 1, 0, 16'hC0DE, 16'h0000, 16'h9F0B);

        for (int v = 0; v < nv; v++) begin
            nm = $sformatf("v%0d", v);
            clear_mon();
            reg_rd_data = vecs[v].rd_val;
            send_frame(frames[v]);
            repeat (30) @(posedge clk);
            @(negedge clk);
            check({nm, "_wr_cnt"},  n_wr,  vecs[v].n_wr);
            check({nm, "_rd_cnt"},  n_rd,  vecs[v].n_rd);
            check({nm, "_err_cnt"}, n_err, vecs[v].n_err);
            if (vecs[v].n_wr > 0) begin
                check({nm, "_wr_addr"}, {16'h0, wr_a}, {16'h0, vecs[v].addr});
                check({nm, "_wr_data"}, {16'h0, wr_d}, {16'h0, vecs[v].data});
                check({nm, "_wr_lat"},  wr_cyc - lf_cyc, 1);
            end
            if (vecs[v].n_rd > 0) begin
                check({nm, "_rd_addr"}, {16'h0, rd_a}, {16'h0, vecs[v].addr});
                check({nm, "_rd_lat"},  rd_cyc - lf_cyc, 1);
            end
            t = exp_tx[v];
            if (vecs[v].n_wr > 0 && ACK) t = "OK\n";
            check_tx(nm, t);
            check({nm, "_idle"}, {31'h0, tx_valid}, 32'h0);
        end

        // Write fields survive later reads and errors.
        check("hold_wr_addr", {16'h0, reg_wr_addr}, 32'h0000_00FF);
        check("hold_wr_data", {16'h0, reg_wr_data}, 32'h0000_0001);
        check("hold_rd_addr", {16'h0, reg_rd_addr}, 32'h0000_C0DE);

        // Transmitter stalled for 50 cycles, with a stray byte during the response.
        clear_mon();
        tx_ready = 1'b0;
        reg_rd_data = 16'hAAAA;
        send_frame("000aR\n");
        for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
        check("stall_valid", {31'h0, tx_valid}, 32'h1);
        first = tx_data;
        check("stall_first", {24'h0, first}, 32'h61);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== first) bad++;
        end
        send_byte(8'h5A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== first) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_err", n_err, 1);
        @(posedge clk); #2;
        tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_rd_cnt", n_rd, 1);
        check_tx("stall", "aaaa\n");

        // Reset in the middle of an address field.
        clear_mon();
        send_frame("00");
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        send_frame("0001WABCD\n");
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rst_wr_cnt",  n_wr, 1);
        check("rst_wr_addr", {16'h0, wr_a}, 32'h0000_0001);
        check("rst_wr_data", {16'h0, wr_d}, 32'h0000_ABCD);
        check("rst_err_cnt", n_err, 0);

        // Reset while a read response is stalled: the response is abandoned.
        tx_ready = 1'b0;
        reg_rd_data = 16'h1357;
        send_frame("0005R\n");
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_mon();
        tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_txv", {31'h0, tx_valid}, 32'h0);
        check("abort_txlen", txq.size(), 0);
        check("abort_strobes", n_wr + n_rd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
